// File: rtl/cell_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : cell_frame_writer
// Purpose  : Packs a raster-order cell stream LSB-first into RAM words and
//            writes them to the back bank of a double-buffered cell RAM.
// Revision : 1.0 - initial release
// ============================================================================
module cell_frame_writer #(
  parameter int P_PARAM_N  = 16,
  parameter int P_PARAM_M  = 16,
  parameter int BLOCK_LEN  = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cell_valid,
  input  logic                  cell_live,
  output logic                  cell_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [BLOCK_LEN-1:0]  wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  display_bank
);

  localparam int TOTAL  = P_PARAM_N * P_PARAM_M;
  localparam int WORDS  = (TOTAL + BLOCK_LEN - 1) / BLOCK_LEN;
  localparam int BIT_W  = $clog2(BLOCK_LEN);
  localparam int CELL_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [BIT_W-1:0]        bitcnt;
  logic [CELL_W-1:0]       cellcnt;
  logic [WORD_W-1:0]       wordcnt;
  logic [BLOCK_LEN-1:0]    pack;
  logic                    write_bank;
  logic [BLOCK_LEN-1:0]    pack_next;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    word_full;

  always_comb begin
    pack_next         = pack;
    pack_next[bitcnt] = cell_live;
    base_addr         = write_bank ? ADDR_WIDTH'(WORDS) : '0;
    word_full         = (bitcnt == BIT_W'(BLOCK_LEN - 1)) ||
                        (cellcnt == CELL_W'(TOTAL - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      bitcnt       <= '0;
      cellcnt      <= '0;
      wordcnt      <= '0;
      pack         <= '0;
      write_bank   <= 1'b0;
      cell_ready   <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      display_bank <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_FILL;
            write_bank <= ~display_bank;
            bitcnt     <= '0;
            cellcnt    <= '0;
            wordcnt    <= '0;
            pack       <= '0;
            cell_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_FILL: begin
          if (cell_valid && cell_ready) begin
            pack    <= pack_next;
            bitcnt  <= bitcnt + BIT_W'(1);
            cellcnt <= cellcnt + CELL_W'(1);
            // Capture the word including the bit accepted on this cycle.
            if (word_full) begin
              state      <= S_WRITE;
              cell_ready <= 1'b0;
              wr_en      <= 1'b1;
              wr_addr    <= base_addr + ADDR_WIDTH'(wordcnt);
              wr_data    <= pack_next;
            end
          end
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en   <= 1'b0;
            pack    <= '0;
            bitcnt  <= '0;
            wordcnt <= wordcnt + WORD_W'(1);
            if (wordcnt == WORD_W'(WORDS - 1)) begin
              state        <= S_DONE;
              frame_done   <= 1'b1;
              busy         <= 1'b0;
              display_bank <= write_bank;
            end else begin
              state      <= S_FILL;
              cell_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cell_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_frame_writer
// Purpose  : Scoreboard bench for cell_frame_writer on a 10x4 grid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_frame_writer;

  localparam int N  = 10;
  localparam int M  = 4;
  localparam int BL = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cell_valid = 1'b0;
  logic          cell_live = 1'b0;
  logic          wr_ready = 1'b1;
  logic          cell_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BL-1:0] wr_data;
  logic          busy;
  logic          frame_done;
  logic          display_bank;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BL-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  logic exp_bank_q[$];

  localparam logic [39:0] ALL1  = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] MOD3  = 40'h92_4924_9249;
  localparam logic [39:0] EVEN  = 40'h55_5555_5555;
  localparam logic [39:0] LOW5  = 40'h00_0000_001F;

  cell_frame_writer #(
    .P_PARAM_N (N),
    .P_PARAM_M (M),
    .BLOCK_LEN (BL),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cell_valid  (cell_valid),
    .cell_live   (cell_live),
    .cell_ready  (cell_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .display_bank(display_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every write handshake and frame_done pulse.
  always @(negedge clk) begin
    wr_t  e;
    logic b;
    if (!reset && wr_en && wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (!reset && frame_done) begin
      if (exp_bank_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: display_bank %0d", display_bank);
      end else begin
        b = exp_bank_q.pop_front();
        check("display_bank", 64'(display_bank), 64'(b));
      end
    end
  end

  task automatic expect_frame(input logic [AW-1:0] a0, input logic [BL-1:0] d0,
                              input logic [AW-1:0] a1, input logic [BL-1:0] d1,
                              input logic bank);
    wr_t e;
    e.addr = a0; e.data = d0; exp_q.push_back(e);
    e.addr = a1; e.data = d1; exp_q.push_back(e);
    exp_bank_q.push_back(bank);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic send_cells(input logic [39:0] bits, input int n, input bit gaps,
                            input int start_at, input int stall);
    int left;
    bit acc;
    int cnt;
    left     = stall;
    wr_ready = (stall == 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        cell_valid = 1'b0;
        cell_live  = ~bits[i];
        tick();
      end
      cell_valid = 1'b1;
      cell_live  = bits[i];
      if (i == start_at) start = 1'b1;
      acc = 1'b0;
      cnt = 0;
      while (!acc) begin
        @(negedge clk);
        acc = cell_ready;
        if (wr_en && !wr_ready) begin
          check("stall_cell_ready", 64'(cell_ready), 64'd0);
          if (exp_q.size() > 0) begin
            check("stall_wr_addr", 64'(wr_addr), 64'(exp_q[0].addr));
            check("stall_wr_data", 64'(wr_data), 64'(exp_q[0].data));
          end
          left--;
        end
        tick();
        start = 1'b0;
        if (left <= 0) wr_ready = 1'b1;
        cnt++;
        if (!acc && cnt > 100) begin
          checks++;
          errors++;
          $display("FAIL cell_accept_timeout: cell %0d not accepted, cell_ready %0d", i, cell_ready);
          cell_valid = 1'b0;
          wr_ready   = 1'b1;
          return;
        end
      end
      if (i == BL - 1) begin
        @(negedge clk);
        check("first_word_latency_wr_en", 64'(wr_en), 64'd1);
      end
    end
    cell_valid = 1'b0;
  endtask

  task automatic wait_done();
    int  cnt;
    bit  seen;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        check("busy_at_done", 64'(busy), 64'd0);
      end
      cnt++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: frame_done 0, expected 1 within 60 cycles");
    end
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cell_ready"},   64'(cell_ready),   64'd0);
    check({tag, "_wr_en"},        64'(wr_en),        64'd0);
    check({tag, "_wr_addr"},      64'(wr_addr),      64'd0);
    check({tag, "_wr_data"},      64'(wr_data),      64'd0);
    check({tag, "_busy"},         64'(busy),         64'd0);
    check({tag, "_frame_done"},   64'(frame_done),   64'd0);
    check({tag, "_display_bank"}, 64'(display_bank), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    tick();

    // Full all-live frame lands in bank 1.
    expect_frame(16'd2, 32'hFFFF_FFFF, 16'd3, 32'h0000_00FF, 1'b1);
    pulse_start();
    send_cells(ALL1, 40, 1'b0, -1, 0);
    wait_done();

    // Every third cell live, written to bank 0.
    expect_frame(16'd0, 32'h4924_9249, 16'd1, 32'h0000_0092, 1'b0);
    pulse_start();
    send_cells(MOD3, 40, 1'b0, -1, 0);
    wait_done();

    // Five-cycle RAM stall on the first word.
    expect_frame(16'd2, 32'hFFFF_FFFF, 16'd3, 32'h0000_00FF, 1'b1);
    pulse_start();
    send_cells(ALL1, 40, 1'b0, -1, 5);
    wait_done();

    // Gapped valid and a stray start mid-frame.
    expect_frame(16'd0, 32'h4924_9249, 16'd1, 32'h0000_0092, 1'b0);
    pulse_start();
    send_cells(MOD3, 40, 1'b1, 10, 0);
    wait_done();

    expect_frame(16'd2, 32'h5555_5555, 16'd3, 32'h0000_0055, 1'b1);
    pulse_start();
    send_cells(EVEN, 40, 1'b0, -1, 0);
    wait_done();

    // Abandon a frame after 17 cells.
    pulse_start();
    send_cells(ALL1, 17, 1'b0, -1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    tick();

    expect_frame(16'd2, 32'h0000_001F, 16'd3, 32'h0000_0000, 1'b1);
    pulse_start();
    send_cells(LOW5, 40, 1'b0, -1, 0);
    wait_done();

    repeat (3) tick();
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    check("frames_outstanding", 64'(exp_bank_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
